// File: rtl/shift_sequencer.sv
// Two-requester round-robin front end for a shared 8-bit shift datapath.
// A captured command is executed as repeated passes of up to PASS_MX positions.
module shift_sequencer #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AMT_W   = 4,
    parameter int unsigned PASS_MX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_din,
    input  logic [AMT_W-1:0] req0_shamt,
    input  logic             req0_lr,
    input  logic             req0_al,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_din,
    input  logic [AMT_W-1:0] req1_shamt,
    input  logic             req1_lr,
    input  logic             req1_al,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_dout,
    output logic             out_id,
    output logic             busy
);

    localparam int unsigned PassW = $clog2(PASS_MX + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic               lr_q, lr_d;
    logic               al_q, al_d;
    logic               id_q, id_d;
    logic               rr_last_q, rr_last_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               any_req;
    logic               grant_id;
    logic               idle;
    logic [DW-1:0]      sel_din;
    logic [AMT_W-1:0]   sel_shamt;
    logic               sel_lr;
    logic               sel_al;
    logic [PassW-1:0]   pass_amt;
    logic [AMT_W-1:0]   rem_left;
    logic [DW-1:0]      pass_res;

    always_comb begin
        idle     = (state_q == StIdle);
        any_req  = req0_valid | req1_valid;
        // Under contention the requester that did not win last time goes first.
        grant_id = (req0_valid & req1_valid) ? ~rr_last_q : req1_valid;

        req0_ready = idle & any_req & ~grant_id;
        req1_ready = idle & any_req & grant_id;

        sel_din   = grant_id ? req1_din   : req0_din;
        sel_shamt = grant_id ? req1_shamt : req0_shamt;
        sel_lr    = grant_id ? req1_lr    : req0_lr;
        sel_al    = grant_id ? req1_al    : req0_al;
    end

    always_comb begin
        pass_amt = (rem_q > AMT_W'(PASS_MX)) ? PassW'(PASS_MX) : PassW'(rem_q);
        rem_left = rem_q - AMT_W'(pass_amt);
        if (lr_q) begin
            pass_res = acc_q << pass_amt;
        end else if (al_q) begin
            pass_res = $unsigned($signed(acc_q) >>> pass_amt);
        end else begin
            pass_res = acc_q >> pass_amt;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        lr_d      = lr_q;
        al_d      = al_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    acc_d     = sel_din;
                    rem_d     = sel_shamt;
                    lr_d      = sel_lr;
                    al_d      = sel_al;
                    id_d      = grant_id;
                    rr_last_d = grant_id;
                    state_d   = (sel_shamt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                acc_d = pass_res;
                rem_d = rem_left;
                if (rem_left == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            rem_q       <= '0;
            lr_q        <= 1'b0;
            al_q        <= 1'b0;
            id_q        <= 1'b0;
            rr_last_q   <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            lr_q        <= lr_d;
            al_q        <= al_d;
            id_q        <= id_d;
            rr_last_q   <= rr_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_dout  = acc_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: vector table, hand-written corner sequences and
// randomized commands checked against an arithmetic reference model.
module tb_shift_sequencer;

    typedef struct packed {
        logic [7:0] din;
        logic [3:0] shamt;
        logic       lr;
        logic       al;
    } cmd_t;

    typedef struct {
        logic       id;
        cmd_t       c;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_din = '0, req1_din = '0;
    logic [3:0] req0_shamt = '0, req1_shamt = '0;
    logic       req0_lr = 1'b0, req0_al = 1'b0, req1_lr = 1'b0, req1_al = 1'b0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_dout;
    logic       out_id, busy;

    int errors = 0;
    int checks = 0;
    logic rr_model = 1'b1;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_din   (req0_din),
        .req0_shamt (req0_shamt),
        .req0_lr    (req0_lr),
        .req0_al    (req0_al),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_din   (req1_din),
        .req1_shamt (req1_shamt),
        .req1_lr    (req1_lr),
        .req1_al    (req1_al),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dout   (out_dout),
        .out_id     (out_id),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole shift amount.
    function automatic logic [7:0] ref_shift(input cmd_t c);
        int v;
        if (c.lr) v = int'(c.din) << c.shamt;
        else if (c.al) v = int'($signed(c.din)) >>> c.shamt;
        else v = int'(c.din) >> c.shamt;
        return v[7:0];
    endfunction

    function automatic int ref_lat(input logic [3:0] shamt);
        if (shamt == 4'd0) return 1;
        return (int'(shamt) + 6) / 7 + 1;
    endfunction

    function automatic vec_t mkv(input logic id, input logic [7:0] din, input logic [3:0] sh,
                                 input logic lr, input logic al, input logic [7:0] exp,
                                 input int lat);
        vec_t v;
        v.id = id;
        v.c.din = din;
        v.c.shamt = sh;
        v.c.lr = lr;
        v.c.al = al;
        v.exp = exp;
        v.lat = lat;
        return v;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.din = 8'($urandom);
        c.shamt = 4'($urandom);
        c.lr = 1'($urandom);
        c.al = 1'($urandom);
        return c;
    endfunction

    task automatic drive(input logic v0, input logic v1, input cmd_t c0, input cmd_t c1);
        req0_valid = v0;
        req0_din = c0.din;
        req0_shamt = c0.shamt;
        req0_lr = c0.lr;
        req0_al = c0.al;
        req1_valid = v1;
        req1_din = c1.din;
        req1_shamt = c1.shamt;
        req1_lr = c1.lr;
        req1_al = c1.al;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_model = 1'b1;
    endtask

    // Full transaction: handshake, latency, result, optional output stall, drain.
    task automatic do_cmd(input logic v0, input logic v1, input cmd_t c0, input cmd_t c1,
                          input int stall, input string name, input logic use_exp,
                          input logic [7:0] exp_dout, input int exp_lat);
        logic win;
        cmd_t sel;
        logic [7:0] exp;
        int lat;
        int cyc;
        win = (v0 && v1) ? ~rr_model : v1;
        sel = win ? c1 : c0;
        exp = use_exp ? exp_dout : ref_shift(sel);
        lat = use_exp ? exp_lat : ref_lat(sel.shamt);
        @(negedge clk);
        drive(v0, v1, c0, c1);
        #1;
        chk({name, ".req0_ready"}, 32'(req0_ready), 32'(!win));
        chk({name, ".req1_ready"}, 32'(req1_ready), 32'(win));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_model = win;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, ".latency"}, 32'(cyc), 32'(lat));
        chk({name, ".dout"}, 32'(out_dout), 32'(exp));
        chk({name, ".id"}, 32'(out_id), 32'(win));
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                drive(1'b1, 1'b1, rand_cmd(), rand_cmd());
                @(posedge clk);
                #1;
                chk({name, ".stall_valid"}, 32'(out_valid), 32'd1);
                chk({name, ".stall_dout"}, 32'(out_dout), 32'(exp));
                chk({name, ".stall_id"}, 32'(out_id), 32'(win));
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, ".drain_busy"}, 32'(busy), 32'd0);
        chk({name, ".drain_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Ready rules hold on every cycle: never both high, both low while busy.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("mon.one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (busy) chk("mon.busy_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        cmd_t ca, cb;
        int n;
        logic exp_id;

        vecs[0]  = mkv(1'b0, 8'hB4, 4'd3,  1'b0, 1'b1, 8'hF6, 2);
        vecs[1]  = mkv(1'b1, 8'h81, 4'd9,  1'b1, 1'b0, 8'h00, 3);
        vecs[2]  = mkv(1'b1, 8'h96, 4'd15, 1'b0, 1'b1, 8'hFF, 4);
        vecs[3]  = mkv(1'b0, 8'h5A, 4'd0,  1'b0, 1'b0, 8'h5A, 1);
        vecs[4]  = mkv(1'b0, 8'h01, 4'd7,  1'b1, 1'b0, 8'h80, 2);
        vecs[5]  = mkv(1'b1, 8'h80, 4'd8,  1'b0, 1'b1, 8'hFF, 3);
        vecs[6]  = mkv(1'b0, 8'h80, 4'd8,  1'b0, 1'b0, 8'h00, 3);
        vecs[7]  = mkv(1'b1, 8'h3C, 4'd2,  1'b1, 1'b0, 8'hF0, 2);
        vecs[8]  = mkv(1'b0, 8'h7F, 4'd14, 1'b0, 1'b1, 8'h00, 3);
        vecs[9]  = mkv(1'b1, 8'hC3, 4'd1,  1'b0, 1'b0, 8'h61, 2);
        vecs[10] = mkv(1'b0, 8'h81, 4'd1,  1'b1, 1'b1, 8'h02, 2);
        vecs[11] = mkv(1'b1, 8'hA5, 4'd7,  1'b0, 1'b1, 8'hFF, 2);
        vecs[12] = mkv(1'b0, 8'h40, 4'd6,  1'b0, 1'b1, 8'h01, 2);

        reset_dut();
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_dout", 32'(out_dout), 32'd0);
        chk("reset.out_id", 32'(out_id), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.readys", 32'({req0_ready, req1_ready}), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_cmd(!vecs[i].id, vecs[i].id, vecs[i].c, vecs[i].c, i % 3,
                   $sformatf("vec%0d", i), 1'b1, vecs[i].exp, vecs[i].lat);
        end

        // Output stalled for 5 cycles while requester inputs churn.
        ca = '{din: 8'hB4, shamt: 4'd3, lr: 1'b0, al: 1'b1};
        do_cmd(1'b1, 1'b0, ca, ca, 5, "stall5", 1'b1, 8'hF6, 2);

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        reset_dut();
        ca = '{din: 8'h0F, shamt: 4'd2, lr: 1'b1, al: 1'b0};
        cb = '{din: 8'hF0, shamt: 4'd3, lr: 1'b0, al: 1'b0};
        @(negedge clk);
        drive(1'b1, 1'b1, ca, cb);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id = 1'(k % 2);
            chk("rr.req0_ready", 32'(req0_ready), 32'(!exp_id));
            chk("rr.req1_ready", 32'(req1_ready), 32'(exp_id));
            @(posedge clk);
            #1;
            n = 1;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rr.out_id", 32'(out_id), 32'(exp_id));
            chk("rr.out_dout", 32'(out_dout), exp_id ? 32'h1E : 32'h3C);
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rr_model = 1'b1;

        // Reset mid-SHIFT after a req0 grant; reset must restore req0 priority.
        @(negedge clk);
        ca = '{din: 8'h55, shamt: 4'd14, lr: 1'b1, al: 1'b0};
        drive(1'b1, 1'b0, ca, ca);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("rst.busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.out_dout", 32'(out_dout), 32'd0);
        chk("rst.out_id", 32'(out_id), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_model = 1'b1;
        ca = '{din: 8'hC0, shamt: 4'd2, lr: 1'b0, al: 1'b1};
        cb = '{din: 8'h0C, shamt: 4'd2, lr: 1'b1, al: 1'b0};
        do_cmd(1'b1, 1'b1, ca, cb, 0, "post_rst", 1'b1, 8'hF0, 2);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            int pat;
            pat = int'($urandom_range(0, 2));
            do_cmd(pat != 1, pat != 0, rand_cmd(), rand_cmd(), int'($urandom_range(0, 2)),
                   $sformatf("rand%0d", r), 1'b0, 8'h00, 0);
        end

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
